lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
- Single-clock, register/RAM-backed last-in-first-out buffer with FIFO-style status flags: empty, almost_empty, almost_full, full, and fill count.
- Sits between a producer (write request plus data) and a consumer (read request), and returns the most recently written word first.
- Depth is 2**AWIDTH words of DWIDTH bits.

Parameters:
- DWIDTH, 16, data word width in bits.
- AWIDTH, 8, address width; depth = 2**AWIDTH.
- ALMOST_FULL, 2, almost_full_o asserts when usedw >= 2**AWIDTH - ALMOST_FULL.
- ALMOST_EMPTY, 2, almost_empty_o asserts when usedw <= ALMOST_EMPTY.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  reset, synchronous, active-low.
- wrreq_i  in  1  push request.
- data_i  in  DWIDTH  push data.
- rdreq_i  in  1  pop request.
- q_o  out  DWIDTH  popped data.
- almost_empty_o  out  1  usedw <= ALMOST_EMPTY.
- empty_o  out  1  usedw == 0.
- almost_full_o  out  1  usedw >= 2**AWIDTH - ALMOST_FULL.
- full_o  out  1  usedw == 2**AWIDTH.
- usedw_o  out  AWIDTH+1  number of stored words, 0..2**AWIDTH.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset, sampled on a clock edge with srst_i == 0:
  - usedw_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0, q_o = 0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all stored data in that cycle and overrides any wrreq_i/rdreq_i.
- Status flags are combinational decodes of the registered usedw, so they update in the same cycle usedw changes.
- Write-only (wrreq_i = 1, rdreq_i = 0):
  - If not full: mem[usedw] <= data_i, usedw + 1.
  - If full: ignored; contents and usedw unchanged.
- Read-only (rdreq_i = 1, wrreq_i = 0):
  - If not empty: q_o <= mem[usedw-1] on the same edge (one-cycle latency: q_o is valid the cycle after rdreq_i is sampled), usedw - 1.
  - If empty: ignored; q_o holds its previous value.
- Simultaneous read and write, stack not empty:
  - q_o <= current top, and data_i overwrites the top slot.
  - usedw unchanged. This is allowed even when full.
- Simultaneous read and write, stack empty: treated as a write only; q_o holds.
- q_o holds its last value when no successful pop occurs.
- Pointer arithmetic uses the AWIDTH+1 bit usedw, with no wrap-around. Overflow and underflow are prevented by the ignore rules above.
- ALMOST_FULL and ALMOST_EMPTY must lie in 0..2**AWIDTH. Out-of-range values fail elaboration via an assertion.

Optional Feature:
- Macro: LIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow_o (1 bit) and underflow_o (1 bit).
  - overflow_o sets on a write-only request while full.
  - underflow_o sets on a read request while empty.
  - Both are sticky until reset, reset value 0, and assert the cycle after the offending request.
- Not defined: ports absent; illegal requests are silently ignored as above.

Test Plan:
- Reset then idle → usedw_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0, q_o = 0.
- Push 0x0001, 0x0002, 0x0003, then 3 pops (defaults) → q_o = 0x0003, 0x0002, 0x0001, each one cycle after its rdreq; usedw goes 3→2→1→0; empty_o = 1 at end; almost_empty_o deasserts at usedw = 3.
- Push 256 words 0..255, then pop 256 → full_o = 1 at usedw = 256; almost_full_o from usedw = 254; pops return 255 down to 0; empty_o = 1 at end.
- Push 300 words 0..299, then 300 pops → pushes 256..299 ignored; usedw stays 256; pops return 255..0; pops 257..300 ignored with q_o holding 0. With LIFO_ERR_FLAGS_EN, overflow_o = 1 and underflow_o = 1.
- Push 0xAAAA, 0xBBBB, then one cycle with wrreq = rdreq = 1 and data 0xCCCC → q_o = 0xBBBB, usedw stays 2; next pop returns 0xCCCC, then 0xAAAA.
- Push 5 words, assert srst_i = 0 for one cycle together with a wrreq → usedw_o = 0, empty_o = 1; a subsequent pop is ignored.

Source files
------------

// File: rtl/lifo_stack.sv
// Last-in-first-out stack with FIFO-style status flags; depth 2**AWIDTH words of DWIDTH bits.
// Pop data appears one cycle after rdreq_i. Define LIFO_ERR_FLAGS_EN to add sticky overflow_o/underflow_o.
module lifo_stack #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              almost_empty_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o
`ifdef LIFO_ERR_FLAGS_EN
    ,
    output logic              overflow_o,
    output logic              underflow_o
`endif
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_LVL  = (AWIDTH+1)'(DEPTH - ALMOST_FULL);
    localparam logic [AWIDTH:0]   AE_LVL  = (AWIDTH+1)'(ALMOST_EMPTY);
    localparam logic [AWIDTH:0]   ONE_W   = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] ONE_A   = {{(AWIDTH-1){1'b0}}, 1'b1};

    generate
        if (ALMOST_FULL < 0 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
            $error("lifo_stack: ALMOST_FULL must lie in 0..2**AWIDTH");
        end
        if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH) begin : g_bad_almost_empty
            $error("lifo_stack: ALMOST_EMPTY must lie in 0..2**AWIDTH");
        end
    endgenerate

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH:0]   usedw_q, usedw_d;
    logic [DWIDTH-1:0] q_q, q_d;
    logic [AWIDTH-1:0] top_idx;
    logic [AWIDTH-1:0] mem_waddr;
    logic              mem_we;
    logic              is_empty, is_full;
    logic              do_push, do_pop, do_swap;

    assign is_empty = (usedw_q == '0);
    assign is_full  = (usedw_q == DEPTH_W);
    // Modular decrement of the low bits also yields DEPTH-1 when the stack is full.
    assign top_idx  = usedw_q[AWIDTH-1:0] - ONE_A;

    // A read on an empty stack together with a write degrades to a plain push.
    assign do_push = wrreq_i && !is_full && (!rdreq_i || is_empty);
    assign do_pop  = rdreq_i && !wrreq_i && !is_empty;
    assign do_swap = rdreq_i && wrreq_i && !is_empty;

    always_comb begin
        usedw_d   = usedw_q;
        q_d       = q_q;
        mem_we    = 1'b0;
        mem_waddr = usedw_q[AWIDTH-1:0];
        if (do_push) begin
            usedw_d = usedw_q + ONE_W;
            mem_we  = 1'b1;
        end
        if (do_pop) begin
            usedw_d = usedw_q - ONE_W;
            q_d     = mem[top_idx];
        end
        if (do_swap) begin
            q_d       = mem[top_idx];
            mem_we    = 1'b1;
            mem_waddr = top_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            usedw_q <= '0;
            q_q     <= '0;
        end else begin
            usedw_q <= usedw_d;
            q_q     <= q_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i && mem_we) begin
            mem[mem_waddr] <= data_i;
        end
    end

    assign q_o            = q_q;
    assign usedw_o        = usedw_q;
    assign empty_o        = is_empty;
    assign full_o         = is_full;
    assign almost_empty_o = (usedw_q <= AE_LVL);
    assign almost_full_o  = (usedw_q >= AF_LVL);

`ifdef LIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (wrreq_i && !rdreq_i && is_full);
        underflow_d = underflow_q | (rdreq_i && is_empty);
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: stimulus queues the expected state after each edge, a monitor checks it.
module tb_lifo_stack;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic        wrreq = 1'b0;
    logic        rdreq = 1'b0;
    logic [15:0] data = '0;
    logic [15:0] q_o;
    logic        almost_empty_o, empty_o, almost_full_o, full_o;
    logic [8:0]  usedw_o;
`ifdef LIFO_ERR_FLAGS_EN
    logic        overflow_o, underflow_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] q;
        logic [8:0]  used;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    lifo_stack #(
        .DWIDTH(16), .AWIDTH(8), .ALMOST_FULL(2), .ALMOST_EMPTY(2)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .wrreq_i        (wrreq),
        .data_i         (data),
        .rdreq_i        (rdreq),
        .q_o            (q_o),
        .almost_empty_o (almost_empty_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .full_o         (full_o),
        .usedw_o        (usedw_o)
`ifdef LIFO_ERR_FLAGS_EN
        ,
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
`endif
    );

    // Flag thresholds for the default parameters: almost_empty <= 2, almost_full >= 254, full == 256.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (q_o !== mon_e.q || usedw_o !== mon_e.used ||
                empty_o !== (mon_e.used == 9'd0) ||
                almost_empty_o !== (mon_e.used <= 9'd2) ||
                almost_full_o !== (mon_e.used >= 9'd254) ||
                full_o !== (mon_e.used == 9'd256)) begin
                n_err++;
                $display("FAIL vec%0d: got q=%h used=%0d e=%b ae=%b af=%b f=%b, want q=%h used=%0d e=%b ae=%b af=%b f=%b",
                         n_vec, q_o, usedw_o, empty_o, almost_empty_o, almost_full_o, full_o,
                         mon_e.q, mon_e.used, mon_e.used == 9'd0, mon_e.used <= 9'd2,
                         mon_e.used >= 9'd254, mon_e.used == 9'd256);
            end
        end
    end

    task automatic step(input logic wr, input logic rd, input logic rst_n,
                        input logic [15:0] d, input logic [15:0] eq, input logic [8:0] eu);
        exp_t e;
        @(negedge clk);
        wrreq = wr;
        rdreq = rd;
        srst  = rst_n;
        data  = d;
        @(posedge clk);
        e.q    = eq;
        e.used = eu;
        sb.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        // Reset and idle
        step(0, 0, 0, 16'h0, 16'h0, 9'd0);
        step(1, 1, 0, 16'h1234, 16'h0, 9'd0);
        step(0, 0, 1, 16'h0, 16'h0, 9'd0);

        // Three pushes then three pops
        step(1, 0, 1, 16'h0001, 16'h0, 9'd1);
        step(1, 0, 1, 16'h0002, 16'h0, 9'd2);
        step(1, 0, 1, 16'h0003, 16'h0, 9'd3);
        step(0, 1, 1, 16'h0, 16'h0003, 9'd2);
        step(0, 1, 1, 16'h0, 16'h0002, 9'd1);
        step(0, 1, 1, 16'h0, 16'h0001, 9'd0);

        // Fill to exactly full, swap at full, then drain
        for (int i = 0; i < 256; i++)
            step(1, 0, 1, 16'(i), 16'h0001, 9'(i + 1));
        step(1, 1, 1, 16'hF00D, 16'd255, 9'd256);
        for (int j = 0; j < 256; j++)
            step(0, 1, 1, 16'h0, (j == 0) ? 16'hF00D : 16'(255 - j), 9'(255 - j));

        // Overfill and over-drain
        for (int i = 0; i < 300; i++)
            step(1, 0, 1, 16'(i), 16'd0, (i < 256) ? 9'(i + 1) : 9'd256);
        for (int j = 0; j < 300; j++)
            step(0, 1, 1, 16'h0, (j < 256) ? 16'(255 - j) : 16'd0, (j < 256) ? 9'(255 - j) : 9'd0);
`ifdef LIFO_ERR_FLAGS_EN
        @(negedge clk);
        check_bit("overflow", overflow_o, 1'b1);
        check_bit("underflow", underflow_o, 1'b1);
`endif

        // Simultaneous read/write: not empty swaps top, empty acts as push
        step(1, 0, 1, 16'hAAAA, 16'h0, 9'd1);
        step(1, 0, 1, 16'hBBBB, 16'h0, 9'd2);
        step(1, 1, 1, 16'hCCCC, 16'hBBBB, 9'd2);
        step(0, 1, 1, 16'h0, 16'hCCCC, 9'd1);
        step(0, 1, 1, 16'h0, 16'hAAAA, 9'd0);
        step(1, 1, 1, 16'h0055, 16'hAAAA, 9'd1);
        step(0, 1, 1, 16'h0, 16'h0055, 9'd0);

        // Reset mid-operation overrides a concurrent write
        for (int i = 0; i < 5; i++)
            step(1, 0, 1, 16'(16'h10 + i), 16'h0055, 9'(i + 1));
        step(1, 0, 0, 16'h9999, 16'h0, 9'd0);
        step(0, 1, 1, 16'h0, 16'h0, 9'd0);
        step(0, 0, 1, 16'h0, 16'h0, 9'd0);
`ifdef LIFO_ERR_FLAGS_EN
        @(negedge clk);
        check_bit("overflow_after_rst", overflow_o, 1'b0);
        check_bit("underflow_after_pop_empty", underflow_o, 1'b1);
`endif

        @(negedge clk);
        wrreq = 1'b0;
        rdreq = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
